// File: rtl/digitube_pkg.sv
// digitube_pkg: constants and anode-decode helpers shared by the scan-latch blocks
// and the legacy combinational scan converter.
package digitube_pkg;
   localparam logic [63:0] BLANK = '1;
   function automatic logic onehot0_low(input logic [15:0] an);
      logic [15:0] x;
      x = ~an;
      return (x != 16'd0) && ((x & (x - 16'd1)) == 16'd0);
   endfunction
   function automatic logic [3:0] first_zero(input logic [15:0] an);
      first_zero = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (!an[i]) first_zero = 4'(i);
   endfunction
endpackage

// File: rtl/digitube_digit_hold.sv
// digitube_digit_hold: per-digit segment latch with valid flag and refresh timeout.
module digitube_digit_hold
   import digitube_pkg::*;
#(
   parameter int SEG_W   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cap_en,
   input  logic [SEG_W-1:0] i_cap_seg,
   output logic [SEG_W-1:0] o_seg,
   output logic             o_valid
);
   logic [SEG_W-1:0] r_seg;
   logic             r_valid;
   assign o_seg   = r_seg;
   assign o_valid = r_valid;
   if (TIMEOUT == 0) begin : g_hold
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_seg   <= BLANK[SEG_W-1:0];
            r_valid <= 1'b0;
         end else if (i_cap_en) begin
            r_seg   <= i_cap_seg;
            r_valid <= 1'b1;
         end
      end
   end else begin : g_tmo
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] r_tcnt;
      logic [TW-1:0] w_tnext;
      assign w_tnext = r_tcnt + 1'b1;
      // capture has priority over the timeout landing on the same cycle
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_seg   <= BLANK[SEG_W-1:0];
            r_valid <= 1'b0;
            r_tcnt  <= '0;
         end else if (i_cap_en) begin
            r_seg   <= i_cap_seg;
            r_valid <= 1'b1;
            r_tcnt  <= '0;
         end else if (r_tcnt != TW'(TIMEOUT)) begin
            r_tcnt <= w_tnext;
            if (w_tnext == TW'(TIMEOUT)) begin
               r_seg   <= BLANK[SEG_W-1:0];
               r_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: rtl/digitube_scan_latch.sv
// digitube_scan_latch: turns a scanned active-low digit-tube bus into static
// per-digit segment words, capturing only after the bus has settled.
module digitube_scan_latch
   import digitube_pkg::*;
#(
   parameter int NDIGIT  = 4,
   parameter int SEG_W   = 8,
   parameter int STABLE  = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NDIGIT-1:0]       an_in,
   input  logic [SEG_W-1:0]        seg_in,
   output logic [NDIGIT*SEG_W-1:0] seg_out,
   output logic [NDIGIT-1:0]       valid_out,
   output logic                    multi_err
);
   localparam int SW = $clog2(STABLE + 1);
   logic [NDIGIT-1:0] r_an;
   logic [SEG_W-1:0]  r_seg;
   logic [SW-1:0]     r_stab;
   logic [15:0]       w_an_pad;
   logic [15:0]       w_in_pad;
   logic              w_legal;
   logic              w_multi_in;
   logic              w_cap;
   logic [3:0]        w_sel;
   always_comb begin
      w_an_pad             = '1;
      w_an_pad[NDIGIT-1:0] = r_an;
      w_in_pad             = '1;
      w_in_pad[NDIGIT-1:0] = an_in;
   end
   assign w_legal    = onehot0_low(w_an_pad);
   assign w_multi_in = !onehot0_low(w_in_pad) && (an_in != '1);
   assign w_sel      = first_zero(w_an_pad);
   assign w_cap      = w_legal && (r_stab >= SW'(STABLE));
   assign multi_err  = !w_legal && (r_an != '1);
   // idle bus is the cleared sample so reset never looks like a multi-select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an   <= '1;
         r_seg  <= BLANK[SEG_W-1:0];
         r_stab <= '0;
      end else begin
         r_an   <= an_in;
         r_seg  <= seg_in;
         r_stab <= w_multi_in ? '0 :
                   ({an_in, seg_in} != {r_an, r_seg}) ? SW'(1) :
                   (r_stab == SW'(STABLE)) ? r_stab : r_stab + 1'b1;
      end
   end
   for (genvar d = 0; d < NDIGIT; d++) begin : g_digit
      digitube_digit_hold #(
         .SEG_W  (SEG_W),
         .TIMEOUT(TIMEOUT)
      ) u_hold (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_cap_en (w_cap && (w_sel == 4'(d))),
         .i_cap_seg(r_seg),
         .o_seg    (seg_out[d*SEG_W +: SEG_W]),
         .o_valid  (valid_out[d])
      );
   end
endmodule

// File: tb/tb_digitube_scan_latch.sv
// tb_digitube_scan_latch: directed checks of capture, scan, glitch, multi-select,
// timeout and reset behaviour with hand-computed expectations.
module tb_digitube_scan_latch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an_in = 4'hF;
   logic [7:0]  seg_in = 8'hFF;
   logic [31:0] seg_out;
   logic [3:0]  valid_out;
   logic        multi_err;
   int          total = 0;
   int          bad = 0;

   digitube_scan_latch #(
      .NDIGIT (4),
      .SEG_W  (8),
      .STABLE (2),
      .TIMEOUT(16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .an_in    (an_in),
      .seg_in   (seg_in),
      .seg_out  (seg_out),
      .valid_out(valid_out),
      .multi_err(multi_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] an, input logic [7:0] seg);
      an_in  = an;
      seg_in = seg;
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++;
      if (seg_out !== 32'hFFFF_FFFF || valid_out !== 4'b0000 || multi_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state seg=%h valid=%b merr=%b want FFFFFFFF 0000 0", seg_out, valid_out, multi_err);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_capture();
      drive(4'b1110, 8'hC0);
      tick();
      tick();
      total++;
      if (seg_out !== 32'hFFFF_FFFF || valid_out !== 4'b0000) begin
         bad++;
         $display("FAIL basic_early seg=%h valid=%b want FFFFFFFF 0000", seg_out, valid_out);
      end
      tick();
      total++;
      if (seg_out !== 32'hFFFF_FFC0 || valid_out !== 4'b0001) begin
         bad++;
         $display("FAIL basic_capture seg=%h valid=%b want FFFFFFC0 0001", seg_out, valid_out);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] an_t [4];
      logic [7:0] seg_t[4];
      an_t  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seg_t = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
      for (int r = 0; r < 3; r++)
         for (int d = 0; d < 4; d++)
            for (int c = 0; c < 4; c++) begin
               drive(an_t[d], seg_t[d]);
               tick();
               if (r > 0) begin
                  total++;
                  if (seg_out !== 32'h99B0_A4F9 || valid_out !== 4'b1111 || multi_err !== 1'b0) begin
                     bad++;
                     $display("FAIL round_robin r=%0d d=%0d c=%0d seg=%h valid=%b merr=%b want 99B0A4F9 1111 0",
                              r, d, c, seg_out, valid_out, multi_err);
                  end
               end
            end
   endtask

   task automatic test_glitch();
      logic [7:0] seg_t[7];
      seg_t = '{8'hB0, 8'hB0, 8'hB0, 8'h00, 8'hB0, 8'hB0, 8'hB0};
      for (int c = 0; c < 7; c++) begin
         drive(4'b1011, seg_t[c]);
         tick();
         total++;
         if (seg_out[23:16] !== 8'hB0 || valid_out[2] !== 1'b1) begin
            bad++;
            $display("FAIL glitch c=%0d dig2=%h v2=%b want B0 1", c, seg_out[23:16], valid_out[2]);
         end
      end
   endtask

   task automatic test_multi_select();
      drive(4'b1110, 8'hC0);
      repeat (3) tick();
      total++;
      if (seg_out[7:0] !== 8'hC0) begin
         bad++;
         $display("FAIL multi_pre0 dig0=%h want C0", seg_out[7:0]);
      end
      drive(4'b1101, 8'hF9);
      repeat (3) tick();
      total++;
      if (seg_out[15:0] !== 16'hF9C0 || valid_out[1:0] !== 2'b11) begin
         bad++;
         $display("FAIL multi_pre01 dig10=%h v=%b want F9C0 11", seg_out[15:0], valid_out[1:0]);
      end
      drive(4'b1100, 8'h88);
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if (multi_err !== 1'b1 || seg_out[15:0] !== 16'hF9C0 || valid_out[1:0] !== 2'b11) begin
            bad++;
            $display("FAIL multi_sel c=%0d merr=%b dig10=%h v=%b want 1 F9C0 11",
                     c, multi_err, seg_out[15:0], valid_out[1:0]);
         end
      end
      drive(4'hF, 8'hFF);
      tick();
      total++;
      if (multi_err !== 1'b0 || seg_out[15:0] !== 16'hF9C0) begin
         bad++;
         $display("FAIL multi_end merr=%b dig10=%h want 0 F9C0", multi_err, seg_out[15:0]);
      end
   endtask

   task automatic test_timeout();
      drive(4'b0111, 8'h92);
      repeat (3) tick();
      total++;
      if (seg_out[31:24] !== 8'h92 || valid_out[3] !== 1'b1) begin
         bad++;
         $display("FAIL timeout_cap dig3=%h v3=%b want 92 1", seg_out[31:24], valid_out[3]);
      end
      drive(4'hF, 8'hFF);
      tick();
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k >= 14) begin
            total++;
            if (seg_out[31:24] !== (k < 16 ? 8'h92 : 8'hFF) || valid_out[3] !== (k < 16)) begin
               bad++;
               $display("FAIL timeout k=%0d dig3=%h v3=%b want %h %b",
                        k, seg_out[31:24], valid_out[3], (k < 16 ? 8'h92 : 8'hFF), (k < 16));
            end
         end
      end
   endtask

   task automatic test_capture_wins();
      drive(4'b0111, 8'h92);
      repeat (3) tick();
      drive(4'hF, 8'hFF);
      tick();
      for (int k = 1; k <= 18; k++) begin
         if (k == 14) drive(4'b0111, 8'h92);
         tick();
         if (k >= 13) begin
            total++;
            if (seg_out[31:24] !== 8'h92 || valid_out[3] !== 1'b1) begin
               bad++;
               $display("FAIL capture_wins k=%0d dig3=%h v3=%b want 92 1", k, seg_out[31:24], valid_out[3]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (seg_out !== 32'hFFFF_FFFF || valid_out !== 4'b0000 || multi_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_async seg=%h valid=%b merr=%b want FFFFFFFF 0000 0", seg_out, valid_out, multi_err);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      total++;
      if (seg_out !== 32'hFFFF_FFFF || valid_out !== 4'b0000) begin
         bad++;
         $display("FAIL reset_window seg=%h valid=%b want FFFFFFFF 0000", seg_out, valid_out);
      end
      tick();
      total++;
      if (seg_out !== 32'h92FF_FFFF || valid_out !== 4'b1000) begin
         bad++;
         $display("FAIL reset_recap seg=%h valid=%b want 92FFFFFF 1000", seg_out, valid_out);
      end
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_round_robin();
      test_glitch();
      test_multi_select();
      test_timeout();
      test_capture_wins();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
